instr_fetch: RTL and testbench

- Fetch stage of the 8-bit CPU.
- Holds the program counter and reads one 8-bit instruction per fetch from instruction memory over a req/ack handshake.
- Presents the instruction, its PC and its 2-bit opcode to decode/control_unit with a valid/ready handshake.
- Accepts a redirect (branch/jump) that discards the fetch in flight.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/pc_reg.sv | 48 ++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the 8-bit CPU: fetch FSM state
//                encodings, opcode field position, default reset PC and the
//                opcode constants decoded by control_unit.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   // Opcode occupies the top two bits of an 8-bit instruction.
   localparam int OPCODE_MSB = 7;
   localparam int OPCODE_LSB = 6;

   localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

   // Opcode constants shared with control_unit.
   localparam logic [1:0] OP_ALU = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : Program counter register. Async reset to RESET_PC, load has
//                priority over increment, increment wraps modulo 2^ADDR_W.
//  Ports       : clk, rst       - clock, async active-high reset
//                inc_en         - advance PC by one
//                load_en        - load load_val (wins over inc_en)
//                load_val       - value to load
//                pc             - current PC
//  Revision    : 1.0  initial release
// ============================================================================
module pc_reg #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_en,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_val;
      end else if (inc_en) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage of the 8-bit CPU. Reads one instruction per
//                fetch over a req/ack port, hands it to decode over
//                valid/ready, and accepts redirects that flush the fetch.
//  Ports       : clk, rst                  - clock, async active-high reset
//                imem_req/addr/rdata/ack   - instruction memory read port
//                id_valid/id_ready         - decode handshake
//                instr/opcode/pc_out       - fetched instruction bundle
//                redirect/redirect_pc      - branch/jump target load
//                stall_cnt                 - decode stall cycles (optional)
//  Config      : define IFETCH_STALL_CNT_EN to add the stall_cnt port and
//                its saturating counter.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ack,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [1:0]         opcode,
   output logic [ADDR_W-1:0]  pc_out,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFETCH_STALL_CNT_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);

   fetch_state_e       state_d, state_q;
   logic [INSTR_W-1:0] instr_d, instr_q;
   logic [ADDR_W-1:0]  pc_out_d, pc_out_q;
   logic [ADDR_W-1:0]  pc;
   logic               pc_inc;
   logic               pc_load;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst      (rst),
      .inc_en   (pc_inc),
      .load_en  (pc_load),
      .load_val (redirect_pc),
      .pc       (pc)
   );

   // Redirect loads the PC in every state; outside S_IDLE it also discards
   // any simultaneous ack or id_ready and restarts the fetch.
   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      pc_inc   = 1'b0;
      pc_load  = redirect;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (redirect) begin
               state_d = S_REQ;
            end else if (imem_ack) begin
               instr_d  = imem_rdata;
               pc_out_d = pc;
               pc_inc   = 1'b1;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect || id_ready) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         pc_out_q <= '0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
      end
   end

   // All handshake outputs decode from registered state only.
   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc;
   assign id_valid  = (state_q == S_HOLD);
   assign instr     = instr_q;
   assign opcode    = instr_q[INSTR_W-1:INSTR_W-2];
   assign pc_out    = pc_out_q;

`ifdef IFETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_HOLD) && !id_ready && !redirect &&
          (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. Memory model returns
//                addr ^ 8'hA5 with a programmable ack delay. Expected
//                instructions are queued per phase; a monitor pops and
//                compares on every decode acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_ack;
   logic       id_valid;
   logic       id_ready;
   logic [7:0] instr;
   logic [1:0] opcode;
   logic [7:0] pc_out;
   logic       redirect;
   logic [7:0] redirect_pc;
`ifdef IFETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [7:0] ins;
      logic [7:0] pc;
   } exp_t;
   exp_t exp_q[$];

   int ack_delay = 0;
   int wait_cnt;

   always #5 clk = ~clk;

   instr_fetch #(
      .ADDR_W   (8),
      .INSTR_W  (8),
      .RESET_PC (8'h00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .instr       (instr),
      .opcode      (opcode),
      .pc_out      (pc_out),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef IFETCH_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // Stateless memory: mem[i] = i ^ 8'hA5, ack after ack_delay wait cycles.
   assign imem_rdata = imem_addr ^ 8'hA5;
   assign imem_ack   = imem_req && (wait_cnt >= ack_delay);

   always @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " imem_req"},  32'(imem_req),  32'h0);
      chk({tag, " imem_addr"}, 32'(imem_addr), 32'h00);
      chk({tag, " id_valid"},  32'(id_valid),  32'h0);
      chk({tag, " instr"},     32'(instr),     32'h00);
      chk({tag, " opcode"},    32'(opcode),    32'h0);
      chk({tag, " pc_out"},    32'(pc_out),    32'h00);
`ifdef IFETCH_STALL_CNT_EN
      chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'h0);
`endif
   endtask

   task automatic push(input logic [7:0] ins, input logic [7:0] pc);
      exp_t e;
      e.ins = ins;
      e.pc  = pc;
      exp_q.push_back(e);
   endtask

   // Monitor: samples mid-cycle (inputs change on negedge, edge at +5).
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (!rst && id_valid && id_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            chk("mon unexpected accept pc_out", 32'(pc_out), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("mon instr",  32'(instr),  32'(e.ins));
            chk("mon pc_out", 32'(pc_out), 32'(e.pc));
            chk("mon opcode", 32'(opcode), 32'(e.ins[7:6]));
         end
      end
   end

   initial begin
      rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
      ack_delay = 0;
      repeat (2) @(negedge clk);
      chk_reset_outs("reset");

      // Streaming, same-cycle ack, decode always ready.
      push(8'hA5, 8'h00); push(8'hA4, 8'h01); push(8'hA7, 8'h02); push(8'hA6, 8'h03);
      rst = 1'b0;
      #1 chk("A idle req", 32'(imem_req), 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("A req",   32'(imem_req),  32'h1);
         chk("A addr",  32'(imem_addr), 32'(k));
         chk("A valid0", 32'(id_valid), 32'h0);
         @(negedge clk);
         chk("A valid1", 32'(id_valid), 32'h1);
         chk("A req0",   32'(imem_req), 32'h0);
      end

      // Ack delayed by 3 cycles from a fresh reset.
      @(negedge clk);
      rst = 1'b1; ack_delay = 3;
      @(negedge clk);
      rst = 1'b0;
      push(8'hA5, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("B req held",  32'(imem_req),  32'h1);
         chk("B addr held", 32'(imem_addr), 32'h00);
         chk("B valid0",    32'(id_valid),  32'h0);
      end
      ack_delay = 0;
      @(negedge clk);
      chk("B valid1", 32'(id_valid), 32'h1);
      chk("B pc_out", 32'(pc_out),   32'h00);

      // Decode stalls 5 cycles in S_HOLD.
      @(negedge clk);
      chk("C addr", 32'(imem_addr), 32'h01);
      id_ready = 1'b0;
      push(8'hA4, 8'h01);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("C valid",  32'(id_valid), 32'h1);
         chk("C no req", 32'(imem_req), 32'h0);
         chk("C instr",  32'(instr),    32'hA4);
         chk("C pc_out", 32'(pc_out),   32'h01);
      end
      @(negedge clk);
`ifdef IFETCH_STALL_CNT_EN
      chk("C stall_cnt", 32'(stall_cnt), 32'd5);
`endif
      id_ready = 1'b1;

      // Redirect coinciding with ack: fetched data dropped.
      @(negedge clk);
      chk("D addr", 32'(imem_addr), 32'h02);
      chk("D ack",  32'(imem_ack),  32'h1);
      redirect = 1'b1; redirect_pc = 8'h40;
      @(negedge clk);
      redirect = 1'b0;
      chk("D valid0", 32'(id_valid),  32'h0);
      chk("D req",    32'(imem_req),  32'h1);
      chk("D addr40", 32'(imem_addr), 32'h40);
      chk("D instr kept", 32'(instr), 32'hA4);
      chk("D pc_out kept", 32'(pc_out), 32'h01);
      push(8'hE5, 8'h40);
      @(negedge clk);
      chk("D valid1", 32'(id_valid), 32'h1);

      // PC wrap FE -> FF -> 00.
      @(negedge clk);
      chk("E addr41", 32'(imem_addr), 32'h41);
      redirect = 1'b1; redirect_pc = 8'hFE;
      push(8'h5B, 8'hFE); push(8'h5A, 8'hFF); push(8'hA5, 8'h00);
      @(negedge clk);
      redirect = 1'b0;
      chk("E addrFE", 32'(imem_addr), 32'hFE);
      @(negedge clk);
      @(negedge clk);
      chk("E addrFF", 32'(imem_addr), 32'hFF);
      @(negedge clk);
      chk("E pc_outFF", 32'(pc_out), 32'hFF);
      @(negedge clk);
      chk("E addr00", 32'(imem_addr), 32'h00);
      @(negedge clk);
      chk("E pc_out00", 32'(pc_out), 32'h00);

      // Async reset while a request waits for ack.
      @(negedge clk);
      ack_delay = 5;
      chk("F req pending", 32'(imem_req), 32'h1);
      chk("F addr",        32'(imem_addr), 32'h01);
      #2 rst = 1'b1;
      #1 chk_reset_outs("F async");
      @(negedge clk);
      rst = 1'b0; ack_delay = 0;
      #1 chk("F idle req",  32'(imem_req),  32'h0);
      chk("F idle addr", 32'(imem_addr), 32'h00);
      push(8'hA5, 8'h00); push(8'hA4, 8'h01);
      @(negedge clk);
      chk("F restart req",  32'(imem_req),  32'h1);
      chk("F restart addr", 32'(imem_addr), 32'h00);
      @(negedge clk);
      chk("F restart valid", 32'(id_valid), 32'h1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      id_ready = 1'b0;
      #4 chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog: the directed sequence is short; never hang.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_instr_fetch
`default_nettype wire
